// File: rtl/das_beamformer_stream.sv
// Streaming delay-and-sum beamformer: per-channel circular delay buffers,
// runtime-programmable delays, two-stage read/sum pipeline, valid/ready on both sides.
// Optional feature macro: APOD_EN (per-channel unsigned apodization weights).
module das_beamformer_stream #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned COEF_W    = 8,
  localparam int unsigned CH_W     = $clog2(N_CH),
  localparam int unsigned AW       = $clog2(DEPTH),
`ifdef APOD_EN
  localparam int unsigned OUT_W    = DATA_W + COEF_W + 1 + $clog2(N_CH)
`else
  localparam int unsigned OUT_W    = DATA_W + $clog2(N_CH)
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [AW-1:0]          cfg_delay,
  input  logic [COEF_W-1:0]      cfg_coef,
  input  logic                   rf_valid,
  output logic                   rf_ready,
  input  logic [DATA_W*N_CH-1:0] rf_data_flat,
  output logic                   bf_valid,
  input  logic                   bf_ready,
  output logic [OUT_W-1:0]       bf_data,
  output logic                   busy,
  output logic [1:0]             debug_state
);

  localparam int unsigned KW = $clog2(FRAME_LEN) + 1;
  localparam int unsigned PW = DATA_W + COEF_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_RUN   = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t            state;
  logic [AW-1:0]     delay [N_CH];
  logic [AW-1:0]     maxd;
  logic [AW-1:0]     maxd_c;
  logic [KW-1:0]     n_cnt;
  logic [KW-1:0]     k_cnt;
  logic              s1_valid;
  logic              s1_last;
  logic              bf_last;
  logic [DATA_W-1:0] s1_data [N_CH];
  logic [DATA_W-1:0] mem [N_CH][DEPTH];
  logic [DATA_W-1:0] rd_c [N_CH];
  logic [KW:0]       rsum_c [N_CH];
  logic [OUT_W-1:0]  sum_c;
  logic              stall;
  logic              en;
  logic              accept;
  logic              issue;
  logic              issue_last;
`ifdef APOD_EN
  logic [COEF_W-1:0] weight [N_CH];
  logic [PW-1:0]     prod_c [N_CH];
`else
  logic              unused_cfg;
  assign unused_cfg = ^cfg_coef;
`endif

  // Handshake and issue decode
  assign stall       = bf_valid & ~bf_ready;
  assign en          = ~stall;
  assign rf_ready    = ((state == S_FILL) | (state == S_RUN)) & ~stall;
  assign accept      = rf_valid & rf_ready;
  assign issue       = ((state == S_RUN) & accept) |
                       ((state == S_DRAIN) & en & (k_cnt != KW'(FRAME_LEN)));
  assign issue_last  = issue & (k_cnt == KW'(FRAME_LEN - 1));
  assign busy        = (state != S_IDLE);
  assign debug_state = state;

  // Largest programmed delay, latched on start
  always_comb begin
    maxd_c = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (delay[c] > maxd_c) maxd_c = delay[c];
    end
  end

  // Read address per channel; past-end indices read as zero, and the sample
  // being written this cycle (d_c == MAXD in RUN) is forwarded from the input
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      rd_c[c]   = '0;
      rsum_c[c] = {1'b0, k_cnt} + (KW+1)'(delay[c]);
      if (rsum_c[c] >= (KW+1)'(FRAME_LEN)) rd_c[c] = '0;
      else if ((state == S_RUN) && (delay[c] == maxd))
        rd_c[c] = rf_data_flat[c*DATA_W +: DATA_W];
      else
        rd_c[c] = mem[c][rsum_c[c][AW-1:0]];
    end
  end

  // Stage-2 combine: optional weighting then full-precision sum
  always_comb begin
    sum_c = '0;
    for (int c = 0; c < N_CH; c++) begin
`ifdef APOD_EN
      prod_c[c] = $signed({{(PW-DATA_W){s1_data[c][DATA_W-1]}}, s1_data[c]}) *
                  $signed({{(PW-COEF_W){1'b0}}, weight[c]});
      sum_c = sum_c + {{(OUT_W-PW){prod_c[c][PW-1]}}, prod_c[c]};
`else
      sum_c = sum_c + {{(OUT_W-DATA_W){s1_data[c][DATA_W-1]}}, s1_data[c]};
`endif
    end
  end

  // Control FSM, configuration registers and line counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      maxd  <= '0;
      n_cnt <= '0;
      k_cnt <= '0;
      for (int c = 0; c < N_CH; c++) begin
        delay[c]  <= '0;
`ifdef APOD_EN
        weight[c] <= COEF_W'(1);
`endif
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            maxd  <= maxd_c;
            n_cnt <= '0;
            k_cnt <= '0;
            state <= (maxd_c == '0) ? S_RUN : S_FILL;
          end else if (cfg_we && (32'(cfg_ch) < N_CH)) begin
            delay[cfg_ch]  <= cfg_delay;
`ifdef APOD_EN
            weight[cfg_ch] <= cfg_coef;
`endif
          end
        end
        S_FILL: begin
          if (accept) begin
            n_cnt <= n_cnt + KW'(1);
            if ((n_cnt + KW'(1)) == KW'(maxd)) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            n_cnt <= n_cnt + KW'(1);
            k_cnt <= k_cnt + KW'(1);
            if (n_cnt == KW'(FRAME_LEN - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (issue) k_cnt <= k_cnt + KW'(1);
          if (bf_valid && bf_ready && bf_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pipeline valid/tag flow and output register; everything holds on stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      bf_valid <= 1'b0;
      bf_last  <= 1'b0;
      bf_data  <= '0;
    end else if (en) begin
      s1_valid <= issue;
      s1_last  <= issue_last;
      bf_valid <= s1_valid;
      bf_last  <= s1_last;
      if (s1_valid) bf_data <= sum_c;
    end
  end

  // Delay buffer writes and stage-1 synchronous read
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (accept) mem[c][n_cnt[AW-1:0]] <= rf_data_flat[c*DATA_W +: DATA_W];
      if (en && issue) s1_data[c] <= rd_c[c];
    end
  end

endmodule
